conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised, fully pipelined 3x3 multi-channel convolution engine with valid/ready backpressure. It sits between the line-buffer window generator and the video output stage. It generalises the earlier 1-cycle RGB888 convolver with parameterised channel count and widths, per-frame kernel/configuration latching, a normalising shift with rounding, an absolute-value (edge-magnitude) mode and a per-frame clip counter.

## Interface
- CH, 3, channels per pixel
- PW, 8, bits per channel (unsigned)
- KW, 8, kernel coefficient width (signed two's complement)
- SW, PW+KW+5, internal signed accumulator width (derived, not overridable)
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input window valid
- o_ready  out  1  engine can accept a window this cycle
- i_win  in  9*CH*PW  window; pixel k (0=top-left … 8=bottom-right, raster order) at [k*CH*PW +: CH*PW]; channel c at [c*PW +: PW] within the pixel
- i_sof  in  1  first window of frame (sideband)
- i_eol  in  1  last window of line (sideband)
- i_mode  in  2  00 sharpen {0,-1,0,-1,5,-1,0,-1,0}; 01 strong {-1×4,9,-1×4}; 10 identity; 11 custom
- i_kernel  in  9*KW  custom coefficient k at [k*KW +: KW]
- i_shift  in  4  arithmetic right shift applied to the sum, 0..15
- i_abs  in  1  take |sum| before clamping
- o_valid  out  1  output pixel valid
- i_ready  in  1  downstream accepts
- o_pix  out  CH*PW  result pixel, same channel packing as the input
- o_sof, o_eol  out  1  sideband, aligned with o_pix
- o_clip_cnt  out  16  clipped-channel count for the current frame

## Operation
- Accept occurs when i_valid & o_ready.
- Config (i_mode, i_kernel, i_shift, i_abs) is loaded into active registers only on an accepted beat with i_sof=1; that beat already uses the new config. The inputs are ignored at all other times.
- After reset, active config = mode 10 (identity), shift 0, abs 0.
- Stage 1 (multiply): per channel, 9 products of {1'b0,pixel} × coefficient. Shift and abs are carried as sideband with the beat, so a config change never affects beats already in flight.
- Stage 2 (sum): sign-extend products to SW bits and add the 9 per channel.
- Stage 3 (normalise and output):
  - shift>0: s = (sum + 2^(shift-1)) >>> shift (round half up).
  - shift=0: s = sum.
  - If abs, s = |s|.
  - Clamp to [0, 2^PW-1]; a channel clips when s<0 or s>2^PW-1.
  - Register result into o_pix.
- Clip counter, updated when a beat loads into stage 3:
  - beat with sof: counter = n, where n is the number of clipped channels in that beat;
  - otherwise: counter = min(counter+n, 16'hFFFF).
- Stall: en = !o_valid | i_ready. All stages and o_ready = en advance together; bubbles are carried as invalid stages.

## Timing
- Latency: a beat accepted at edge N appears with o_valid=1 after edge N+3, given no stall.
- Throughput: one beat per cycle.
- Reset values:
  - o_valid=0, o_pix=0, o_sof=0, o_eol=0, o_clip_cnt=0;
  - all stage valids 0;
  - o_ready=1 (combinational from en).
- While o_valid & !i_ready:
  - o_pix, o_sof, o_eol and o_clip_cnt hold;
  - the pipeline freezes and o_ready=0;
  - no input beat is lost or duplicated.
- o_ready may depend combinationally on i_ready. i_valid must not depend on o_ready.
- Reset mid-stream: all in-flight beats are discarded. The first output after release comes from a beat accepted after release, using the identity config until the next sof.
- Sum width SW never overflows: 9 × (2^PW) × 2^(KW-1) fits in SW signed bits.
- The most negative SW value cannot occur, so abs needs no extra bit.

## Test plan
- Identity (default after reset):
  - Stimulus: 3 consecutive beats with centre pixel = 0x112233, 0x445566, 0x778899.
  - Required: same values on o_pix in order, first one 3 cycles after accept; o_clip_cnt=0.
- Sharpen (mode 00, sof):
  - Stimulus: neighbours 100/channel, centre 200.
  - Required: 5·200−4·100=600 → o_pix=0xFFFFFF and o_clip_cnt=3.
  - Next beat: all pixels 100 → o_pix=0x646464; count stays 3.
- Custom blur (mode 11, kernel {1,2,1,2,4,2,1,2,1}, shift 4):
  - Uniform 10 with centre 11 → (164+8)>>4=10.
  - Centre 12 → 176>>4=11 (10.5 rounds up).
- Edge magnitude (kernel {-1,0,1,-2,0,2,-1,0,1}, left column 50, right column 0):
  - abs=1 → 200 per channel.
  - abs=0 → 0 per channel, 3 clips counted.
  - Left column 200, abs=1 → 800 → 255.
- Backpressure:
  - Stimulus: random i_ready at 50% duty over 200 beats.
  - Required: output sequence equals the reference model; o_pix stable while o_valid & !i_ready; o_sof/o_eol stay aligned.
- Config gating and reset:
  - Change i_mode mid-frame without sof → no effect until the next sof beat.
  - Assert iRst_n=0 with 3 beats in flight → o_valid=0 immediately; no stale beat appears after release.

Source files
------------

// File: rtl/conv3x3_stream_if.sv
// Window-in / pixel-out stream bundle for conv3x3_stream.
// The engine is the slave; the source/sink environment is the master.
interface conv3x3_stream_if #(
   parameter int CH = 3,
   parameter int PW = 8,
   parameter int KW = 8
) ();
   logic                i_valid;
   logic                o_ready;
   logic [9*CH*PW-1:0]  i_win;
   logic                i_sof;
   logic                i_eol;
   logic [1:0]          i_mode;
   logic [9*KW-1:0]     i_kernel;
   logic [3:0]          i_shift;
   logic                i_abs;
   logic                o_valid;
   logic                i_ready;
   logic [CH*PW-1:0]    o_pix;
   logic                o_sof;
   logic                o_eol;
   logic [15:0]         o_clip_cnt;

   modport slave (
      input  i_valid, i_win, i_sof, i_eol, i_mode,
      input  i_kernel, i_shift, i_abs, i_ready,
      output o_ready, o_valid, o_pix, o_sof, o_eol,
      output o_clip_cnt
   );

   modport master (
      output i_valid, i_win, i_sof, i_eol, i_mode,
      output i_kernel, i_shift, i_abs, i_ready,
      input  o_ready, o_valid, o_pix, o_sof, o_eol,
      input  o_clip_cnt
   );
endinterface

// File: rtl/conv3x3_stream.sv
// Pipelined 3x3 multi-channel convolution: capture, multiply, sum,
// normalise/clamp. Per-frame config, rounding shift, abs, clip count.
module conv3x3_stream #(
   parameter int CH = 3,
   parameter int PW = 8,
   parameter int KW = 8
) (
   input  logic            iClk,
   input  logic            iRst_n,
   conv3x3_stream_if.slave bus
);
   localparam int SW   = PW + KW + 5;
   localparam int MW   = PW + KW + 1;
   localparam int NW   = SW + 1;
   localparam int XW   = 9 * CH * PW;
   localparam int MAXV = 2**PW - 1;

   localparam logic [KW-1:0] C_M1 = '1;
   localparam logic [KW-1:0] C_0  = '0;
   localparam logic [KW-1:0] C_1  = KW'(1);
   localparam logic [KW-1:0] C_5  = KW'(5);
   localparam logic [KW-1:0] C_9  = KW'(9);

   logic en, acc;
   assign en          = !bus.o_valid || bus.i_ready;
   assign bus.o_ready = en;
   assign acc         = bus.i_valid && en;

   logic [1:0]      cfg_mode;
   logic [9*KW-1:0] cfg_kernel;
   logic [3:0]      cfg_shift;
   logic            cfg_abs;

   logic [1:0]      mode;
   logic [9*KW-1:0] kern;
   logic [3:0]      shift;
   logic            absv;
   logic [9*KW-1:0] coef;

   // An sof beat already runs with the config presented alongside it.
   always_comb begin
      mode  = cfg_mode;
      kern  = cfg_kernel;
      shift = cfg_shift;
      absv  = cfg_abs;
      if (bus.i_sof) begin
         mode  = bus.i_mode;
         kern  = bus.i_kernel;
         shift = bus.i_shift;
         absv  = bus.i_abs;
      end
      coef = '0;
      for (int k = 0; k < 9; k++) begin
         unique case (mode)
            2'b00: coef[k*KW +: KW] = (k == 4) ? C_5 :
                                      ((k % 2) == 1) ? C_M1 : C_0;
            2'b01: coef[k*KW +: KW] = (k == 4) ? C_9 : C_M1;
            2'b10: coef[k*KW +: KW] = (k == 4) ? C_1 : C_0;
            2'b11: coef[k*KW +: KW] = kern[k*KW +: KW];
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cfg_mode   <= 2'b10;
         cfg_kernel <= '0;
         cfg_shift  <= '0;
         cfg_abs    <= 1'b0;
      end else if (acc && bus.i_sof) begin
         cfg_mode   <= bus.i_mode;
         cfg_kernel <= bus.i_kernel;
         cfg_shift  <= bus.i_shift;
         cfg_abs    <= bus.i_abs;
      end
   end

   logic            v0, sof0, eol0, abs0;
   logic [3:0]      sh0;
   logic [XW-1:0]   win0;
   logic [9*KW-1:0] coef0;

   logic                 v1, sof1, eol1, abs1;
   logic [3:0]           sh1;
   logic signed [MW-1:0] prod [CH][9];
   logic signed [MW-1:0] p1   [CH][9];

   logic                 v2, sof2, eol2, abs2;
   logic [3:0]           sh2;
   logic signed [SW-1:0] sum [CH];
   logic signed [SW-1:0] s2  [CH];

   always_comb begin
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < 9; k++)
            prod[c][k] =
               MW'($signed({1'b0, win0[(k*CH+c)*PW +: PW]})) *
               MW'($signed(coef0[k*KW +: KW]));
   end

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         sum[c] = '0;
         for (int k = 0; k < 9; k++)
            sum[c] = sum[c] + SW'(p1[c][k]);
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         v0 <= 1'b0; sof0 <= 1'b0; eol0 <= 1'b0;
         abs0 <= 1'b0; sh0 <= '0; win0 <= '0; coef0 <= '0;
         v1 <= 1'b0; sof1 <= 1'b0; eol1 <= 1'b0;
         abs1 <= 1'b0; sh1 <= '0;
         v2 <= 1'b0; sof2 <= 1'b0; eol2 <= 1'b0;
         abs2 <= 1'b0; sh2 <= '0;
         for (int c = 0; c < CH; c++) begin
            s2[c] <= '0;
            for (int k = 0; k < 9; k++) p1[c][k] <= '0;
         end
      end else if (en) begin
         v0    <= acc;
         sof0  <= bus.i_sof;
         eol0  <= bus.i_eol;
         abs0  <= absv;
         sh0   <= shift;
         win0  <= bus.i_win;
         coef0 <= coef;
         v1    <= v0;
         sof1  <= sof0;
         eol1  <= eol0;
         abs1  <= abs0;
         sh1   <= sh0;
         p1    <= prod;
         v2    <= v1;
         sof2  <= sof1;
         eol2  <= eol1;
         abs2  <= abs1;
         sh2   <= sh1;
         s2    <= sum;
      end
   end

   logic [CH*PW-1:0]     pix_n;
   logic [15:0]          nclip;
   logic [16:0]          cnt_sum;
   logic [15:0]          cnt_n;
   logic signed [NW-1:0] r;

   always_comb begin
      pix_n = '0;
      nclip = '0;
      r     = '0;
      for (int c = 0; c < CH; c++) begin
         r = NW'(s2[c]);
         if (sh2 != 4'd0)
            r = (r + (NW'(1) <<< (sh2 - 4'd1))) >>> sh2;
         if (abs2 && r < 0) r = -r;
         if (r < 0) begin
            nclip = nclip + 16'd1;
         end else if (r > NW'(MAXV)) begin
            pix_n[c*PW +: PW] = '1;
            nclip = nclip + 16'd1;
         end else begin
            pix_n[c*PW +: PW] = r[PW-1:0];
         end
      end
      cnt_sum = {1'b0, bus.o_clip_cnt} + {1'b0, nclip};
      if (sof2)            cnt_n = nclip;
      else if (cnt_sum[16]) cnt_n = 16'hFFFF;
      else                  cnt_n = cnt_sum[15:0];
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         bus.o_valid    <= 1'b0;
         bus.o_pix      <= '0;
         bus.o_sof      <= 1'b0;
         bus.o_eol      <= 1'b0;
         bus.o_clip_cnt <= '0;
      end else if (en) begin
         bus.o_valid <= v2;
         if (v2) begin
            bus.o_pix      <= pix_n;
            bus.o_sof      <= sof2;
            bus.o_eol      <= eol2;
            bus.o_clip_cnt <= cnt_n;
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: directed vector table, random backpressure
// against a behavioural model, and mid-stream reset.
module tb_conv3x3_stream;
   localparam int WINW = 9 * 3 * 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   rand_ready = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   conv3x3_stream_if #(.CH(3), .PW(8), .KW(8)) bus ();

   conv3x3_stream #(.CH(3), .PW(8), .KW(8)) dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus.slave)
   );

   typedef struct {
      logic [WINW-1:0] win;
      bit              sof;
      bit              eol;
      logic [1:0]      mode;
      logic [71:0]     kern;
      logic [3:0]      shift;
      bit              absv;
      logic [23:0]     epix;
      int              ecnt;
   } vec_t;

   typedef struct {
      logic [23:0] pix;
      bit          sof;
      bit          eol;
      logic [15:0] cnt;
      int          id;
   } exp_t;

   exp_t sbq[$];
   vec_t tab[$];

   logic [1:0]  m_mode;
   logic [71:0] m_kern;
   int          m_shift;
   bit          m_abs;
   int          m_cnt;

   localparam logic [71:0] K_BLUR =
      {8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01};
   localparam logic [71:0] K_EDGE =
      {8'h01, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFE, 8'h01, 8'h00, 8'hFF};

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   function automatic logic [23:0] rep(input logic [7:0] v);
      return {v, v, v};
   endfunction

   function automatic logic [WINW-1:0] mkwin(input logic [23:0] nb,
                                             input logic [23:0] ctr);
      logic [WINW-1:0] w;
      for (int k = 0; k < 9; k++) w[k*24 +: 24] = (k == 4) ? ctr : nb;
      return w;
   endfunction

   function automatic logic [WINW-1:0] colwin(input logic [23:0] l);
      logic [WINW-1:0] w = '0;
      w[0*24 +: 24] = l;
      w[3*24 +: 24] = l;
      w[6*24 +: 24] = l;
      return w;
   endfunction

   function automatic vec_t mkv(input logic [WINW-1:0] w, input bit s,
      input bit e, input logic [1:0] m, input logic [71:0] k,
      input logic [3:0] sh, input bit a, input logic [23:0] ep,
      input int ec);
      vec_t v;
      v.win = w; v.sof = s; v.eol = e; v.mode = m; v.kern = k;
      v.shift = sh; v.absv = a; v.epix = ep; v.ecnt = ec;
      return v;
   endfunction

   function automatic void model(input logic [WINW-1:0] w,
      input logic [1:0] m, input logic [71:0] kr, input int sh,
      input bit ab, output logic [23:0] px, output int nc);
      int sharp[9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
      int cf[9];
      int sum, s;
      nc = 0;
      px = '0;
      for (int k = 0; k < 9; k++) begin
         case (m)
            2'b00:   cf[k] = sharp[k];
            2'b01:   cf[k] = (k == 4) ? 9 : -1;
            2'b10:   cf[k] = (k == 4) ? 1 : 0;
            default: cf[k] = int'($signed(kr[k*8 +: 8]));
         endcase
      end
      for (int c = 0; c < 3; c++) begin
         sum = 0;
         for (int k = 0; k < 9; k++)
            sum += cf[k] * int'(w[(k*3+c)*8 +: 8]);
         s = (sh > 0) ? ((sum + (1 << (sh - 1))) >>> sh) : sum;
         if (ab && s < 0) s = -s;
         if (s < 0) begin
            nc++;
         end else if (s > 255) begin
            px[c*8 +: 8] = 8'hFF;
            nc++;
         end else begin
            px[c*8 +: 8] = 8'(s);
         end
      end
   endfunction

   function automatic void model_reset();
      m_mode = 2'b10; m_kern = '0; m_shift = 0; m_abs = 1'b0; m_cnt = 0;
   endfunction

   task automatic accept(input vec_t v, input bit use_tab, input int id);
      logic [23:0] px;
      int nc;
      exp_t e;
      if (v.sof) begin
         m_mode = v.mode; m_kern = v.kern;
         m_shift = int'(v.shift); m_abs = v.absv;
      end
      model(v.win, m_mode, m_kern, m_shift, m_abs, px, nc);
      if (v.sof) m_cnt = nc;
      else m_cnt = (m_cnt + nc > 65535) ? 65535 : m_cnt + nc;
      e.pix = use_tab ? v.epix : px;
      e.cnt = use_tab ? 16'(v.ecnt) : 16'(m_cnt);
      e.sof = v.sof;
      e.eol = v.eol;
      e.id  = id;
      sbq.push_back(e);
   endtask

   task automatic send(input vec_t v, input bit use_tab, input int id);
      int budget = 0;
      bus.i_valid = 1'b1; bus.i_win = v.win; bus.i_sof = v.sof;
      bus.i_eol = v.eol; bus.i_mode = v.mode; bus.i_kernel = v.kern;
      bus.i_shift = v.shift; bus.i_abs = v.absv;
      @(negedge clk);
      while (!bus.o_ready && budget < 1000) begin
         budget++;
         @(negedge clk);
      end
      if (!bus.o_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout[%0d]: o_ready %0b required 1",
                  id, bus.o_ready);
         bus.i_valid = 1'b0;
         return;
      end
      @(posedge clk);
      accept(v, use_tab, id);
      #1 bus.i_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int b = 0;
      while (sbq.size() != 0 && b < 2000) begin
         @(posedge clk);
         b++;
      end
      #1 check(nm, 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1 bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: scoreboard pop on handshake, hold check on stall.
   initial begin
      exp_t e;
      bit stall_prev = 1'b0;
      logic [41:0] held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
            continue;
         end
         if (stall_prev)
            check("stall_hold",
                  64'({bus.o_pix, bus.o_sof, bus.o_eol, bus.o_clip_cnt}),
                  64'(held));
         if (bus.o_valid && !bus.i_ready)
            check("stall_ready", 64'(bus.o_ready), 64'd0);
         if (bus.o_valid && bus.i_ready) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h required none",
                        bus.o_pix);
            end else begin
               e = sbq.pop_front();
               check($sformatf("pix[%0d]", e.id),
                     64'(bus.o_pix), 64'(e.pix));
               check($sformatf("sideband[%0d]", e.id),
                     64'({bus.o_sof, bus.o_eol}), 64'({e.sof, e.eol}));
               check($sformatf("clip_cnt[%0d]", e.id),
                     64'(bus.o_clip_cnt), 64'(e.cnt));
            end
         end
         stall_prev = bus.o_valid && !bus.i_ready;
         held = {bus.o_pix, bus.o_sof, bus.o_eol, bus.o_clip_cnt};
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      bit seen;
      logic [WINW-1:0] w;
      logic [71:0] k;
      vec_t v;

      bus.i_valid = 1'b0; bus.i_win = '0; bus.i_sof = 1'b0;
      bus.i_eol = 1'b0; bus.i_mode = 2'b00; bus.i_kernel = '0;
      bus.i_shift = '0; bus.i_abs = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_pix", 64'(bus.o_pix), 64'd0);
      check("rst_o_sof_eol", 64'({bus.o_sof, bus.o_eol}), 64'd0);
      check("rst_o_clip_cnt", 64'(bus.o_clip_cnt), 64'd0);
      check("rst_o_ready", 64'(bus.o_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      send(mkv(mkwin('0, 24'h0A0B0C), 0, 0, 2'b11, '0, 4'd5, 1,
               '0, 0), 0, 100);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!bus.o_valid && lat < 10);
      check("latency", 64'(lat), 64'd3);
      drain("drain_latency");

      tab.push_back(mkv(mkwin('0, 24'h112233), 0, 0, 2'b11, '0, 4'd0, 0,
                        24'h112233, 0));
      tab.push_back(mkv(mkwin('0, 24'h445566), 0, 1, 2'b00, '0, 4'd0, 0,
                        24'h445566, 0));
      tab.push_back(mkv(mkwin('0, 24'h778899), 0, 0, 2'b00, '0, 4'd0, 0,
                        24'h778899, 0));
      tab.push_back(mkv(mkwin(rep(100), rep(200)), 1, 0, 2'b00, '0, 4'd0,
                        0, 24'hFFFFFF, 3));
      tab.push_back(mkv(mkwin(rep(100), rep(100)), 0, 1, 2'b00, '0, 4'd0,
                        0, 24'h646464, 3));
      tab.push_back(mkv(mkwin(rep(10), rep(11)), 1, 0, 2'b11, K_BLUR, 4'd4,
                        0, 24'h0A0A0A, 0));
      tab.push_back(mkv(mkwin(rep(10), rep(12)), 0, 1, 2'b11, K_BLUR, 4'd4,
                        0, 24'h0B0B0B, 0));
      tab.push_back(mkv(colwin(rep(50)), 1, 0, 2'b11, K_EDGE, 4'd0, 1,
                        24'hC8C8C8, 0));
      tab.push_back(mkv(colwin(rep(50)), 1, 0, 2'b11, K_EDGE, 4'd0, 0,
                        24'h000000, 3));
      tab.push_back(mkv(colwin(rep(200)), 1, 0, 2'b11, K_EDGE, 4'd0, 1,
                        24'hFFFFFF, 3));
      tab.push_back(mkv(colwin(rep(50)), 0, 0, 2'b10, '0, 4'd3, 0,
                        24'hC8C8C8, 3));
      tab.push_back(mkv(colwin(rep(200)), 0, 1, 2'b00, '0, 4'd0, 0,
                        24'hFFFFFF, 6));
      tab.push_back(mkv(mkwin(rep(7), 24'h010203), 1, 0, 2'b10, '0, 4'd0,
                        0, 24'h010203, 0));
      foreach (tab[i]) send(tab[i], 1, i);
      drain("drain_table");

      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         for (int b = 0; b < 27; b++) w[b*8 +: 8] = 8'($urandom);
         for (int b = 0; b < 9; b++) k[b*8 +: 8] = 8'($urandom);
         v = mkv(w, (i % 25) == 0, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), k, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), '0, 0);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(v, 0, 1000 + i);
      end
      drain("drain_random");
      rand_ready = 1'b0;
      @(posedge clk);
      #1;

      send(mkv(mkwin(rep(100), rep(200)), 1, 0, 2'b00, '0, 4'd0, 0,
               '0, 0), 0, 200);
      for (int i = 1; i < 5; i++)
         send(mkv(mkwin(rep(8'(i)), rep(8'(40 + i))), 0, 0, 2'b00, '0,
                  4'd0, 0, '0, 0), 0, 200 + i);
      check("pre_rst_o_valid", 64'(bus.o_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_flush_o_valid", 64'(bus.o_valid), 64'd0);
      sbq.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.o_valid) seen = 1'b1;
      end
      check("no_stale_after_rst", 64'(seen), 64'd0);
      @(posedge clk);
      #1;
      send(mkv(mkwin(rep(9), 24'hC0FFEE), 0, 1, 2'b00, '0, 4'd2, 1,
               24'hC0FFEE, 0), 1, 300);
      drain("drain_post_rst");

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
